// File: rtl/sdram_burst_writer_pkg.sv
// rtl/sdram_burst_writer_pkg.sv - shared types and widths for the SDRAM ring burst writer
package sdram_burst_writer_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int WSIZE_W      = 10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } state_t;

endpackage

// File: rtl/sdram_burst_fifo.sv
// rtl/sdram_burst_fifo.sv - first-word-fall-through FIFO with level output
module sdram_burst_fifo #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = level[AW];
  assign empty   = (level == '0);
  // A pop on an empty FIFO is ignored; a push while full is taken only alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and level bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sdram_burst_writer.sv
// rtl/sdram_burst_writer.sv - capture stream to SDRAM ring burst writer; SDRAM_BURST_WRITER_FLUSH_EN adds idle short-burst flush
module sdram_burst_writer
  import sdram_burst_writer_pkg::*;
#(
  parameter int                ADDR_W     = SDRAM_ADDR_W,
  parameter int                BURST      = 256,
  parameter int                FIFO_AW    = 9,
  parameter logic [ADDR_W-1:0] RING_BASE  = 24'h000000,
  parameter logic [ADDR_W-1:0] RING_WORDS = 24'h100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               user_wreq,
  input  logic               user_wstart,
  input  logic               user_wdone,
  output logic [ADDR_W-1:0]  user_waddr,
  output logic [WSIZE_W-1:0] user_wsize,
  input  logic               user_wen,
  output logic [15:0]        user_wdata,
  input  logic               free_strobe,
  input  logic [WSIZE_W-1:0] free_words,
  output logic [ADDR_W:0]    ring_fill,
  output logic [15:0]        drop_count
);

  localparam int LW  = FIFO_AW + 1;
  localparam int FW  = ADDR_W + 1;
  localparam int FW1 = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] RING_END = RING_BASE + RING_WORDS;

  state_t             state;
  state_t             state_nxt;
  logic               ready_en;
  logic               fifo_full;
  logic               push;
  logic               done;
  logic               start_req;
  logic               burst_ok;
  logic [LW-1:0]      level;
  logic [ADDR_W-1:0]  wptr;
  logic [ADDR_W-1:0]  wptr_adv;
  logic [WSIZE_W-1:0] req_size;
  logic [FW-1:0]      space;
  logic [FW1-1:0]     fill_sum;
  logic [FW1-1:0]     fill_sub;

  // in_ready is held low for the first cycle out of reset, then tracks FIFO space.
  assign in_ready  = ready_en & ~fifo_full;
  assign push      = in_valid & in_ready;
  assign user_wreq = (state == REQ);
  assign done      = (state == XFER) & user_wdone;
  assign space     = {1'b0, RING_WORDS} - ring_fill;
  assign burst_ok  = (level >= LW'(BURST)) && (space >= FW'(BURST));
  assign wptr_adv  = wptr + ADDR_W'(user_wsize);
  // Completed words and returned words can land in the same cycle; the result clamps at zero.
  assign fill_sum  = {1'b0, ring_fill} + (done ? FW1'(user_wsize) : '0);
  assign fill_sub  = free_strobe ? FW1'(free_words) : '0;

  sdram_burst_fifo #(
    .DW(16),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (user_wen),
    .head      (user_wdata),
    .full      (fifo_full),
    .level     (level)
  );

`ifdef SDRAM_BURST_WRITER_FLUSH_EN
  localparam logic [15:0] FLUSH_IDLE = 16'd4096;

  logic [15:0]        idle_cnt;
  logic [ADDR_W-1:0]  room;
  logic [WSIZE_W-1:0] flush_size;
  logic               partial;
  logic               flush_ok;

  assign room       = RING_END - wptr;
  assign partial    = (level != '0) && (level < LW'(BURST));
  assign flush_size = (room < ADDR_W'(level)) ? WSIZE_W'(room) : WSIZE_W'(level);
  assign flush_ok   = (idle_cnt == FLUSH_IDLE) && (space >= FW'(flush_size));

  // Idle timer: counts quiet IDLE cycles while a partial burst sits in the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != IDLE || push || !partial) begin
      idle_cnt <= '0;
    end else if (idle_cnt != FLUSH_IDLE) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and request launch
  always_comb begin
    state_nxt = state;
    start_req = 1'b0;
    req_size  = WSIZE_W'(BURST);
    case (state)
      IDLE: begin
        if (burst_ok) begin
          start_req = 1'b1;
          state_nxt = REQ;
        end
`ifdef SDRAM_BURST_WRITER_FLUSH_EN
        else if (flush_ok) begin
          start_req = 1'b1;
          req_size  = flush_size;
          state_nxt = REQ;
        end
`endif
      end
      REQ:     if (user_wstart) state_nxt = XFER;
      XFER:    if (user_wdone)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, ring write pointer, ring occupancy and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en   <= 1'b0;
      user_waddr <= RING_BASE;
      user_wsize <= '0;
      wptr       <= RING_BASE;
      ring_fill  <= '0;
      drop_count <= '0;
    end else begin
      ready_en <= 1'b1;
      if (start_req) begin
        user_waddr <= wptr;
        user_wsize <= req_size;
      end
      if (done) wptr <= (wptr_adv == RING_END) ? RING_BASE : wptr_adv;
      ring_fill <= (fill_sum > fill_sub) ? FW'(fill_sum - fill_sub) : '0;
      if (in_valid && !in_ready && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdram_burst_writer.sv
// tb/tb_sdram_burst_writer.sv - self-checking bench for sdram_burst_writer (optionally with SDRAM_BURST_WRITER_FLUSH_EN)
module tb_sdram_burst_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        user_wreq;
  logic        user_wstart;
  logic        user_wdone;
  logic [23:0] user_waddr;
  logic [9:0]  user_wsize;
  logic        user_wen;
  logic [15:0] user_wdata;
  logic        free_strobe;
  logic [9:0]  free_words;
  logic [24:0] ring_fill;
  logic [15:0] drop_count;

  logic        free_strobe_tb;
  logic [9:0]  free_words_tb;
  logic        free_strobe_ctl;

  int          checks;
  int          errors;
  logic [15:0] exp_q[$];
  logic [33:0] exp_req[$];
  int          bursts_done;
  bit          half_duty;
  bit          free_on_done;
  int          abort_after;
  bit          aborted;

  always #5 clk = ~clk;

  assign free_strobe = free_strobe_tb | free_strobe_ctl;
  assign free_words  = free_strobe_ctl ? 10'd256 : free_words_tb;

  sdram_burst_writer #(
    .ADDR_W     (24),
    .BURST      (256),
    .FIFO_AW    (9),
    .RING_BASE  (24'h000000),
    .RING_WORDS (24'd512)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .user_wreq   (user_wreq),
    .user_wstart (user_wstart),
    .user_wdone  (user_wdone),
    .user_waddr  (user_waddr),
    .user_wsize  (user_wsize),
    .user_wen    (user_wen),
    .user_wdata  (user_wdata),
    .free_strobe (free_strobe),
    .free_words  (free_words),
    .ring_fill   (ring_fill),
    .drop_count  (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: accepts requests after 3 cycles and consumes the burst
  initial begin
    logic [33:0] r;
    logic [15:0] e;
    int          n;
    int          popped;
    bit          phase;
    user_wstart     = 1'b0;
    user_wen        = 1'b0;
    user_wdone      = 1'b0;
    free_strobe_ctl = 1'b0;
    bursts_done     = 0;
    aborted         = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && user_wreq === 1'b1) begin
        aborted = 1'b0;
        repeat (2) @(negedge clk);
        check("wreq_held", 32'(user_wreq), 32'd1);
        user_wstart = 1'b1;
        @(negedge clk);
        user_wstart = 1'b0;
        check("wreq_drop", 32'(user_wreq), 32'd0);
        check("req_expected", 32'(exp_req.size() != 0), 32'd1);
        if (exp_req.size() != 0) begin
          r = exp_req.pop_front();
          check("waddr", 32'(user_waddr), 32'(r[33:10]));
          check("wsize", 32'(user_wsize), 32'(r[9:0]));
          n = int'(r[9:0]);
        end else begin
          n = int'(user_wsize);
        end
        popped = 0;
        phase  = 1'b0;
        while (popped < n) begin
          if (abort_after != 0 && popped == abort_after) begin
            aborted = 1'b1;
            break;
          end
          if (half_duty && phase) begin
            user_wen = 1'b0;
          end else begin
            user_wen = 1'b1;
            if (exp_q.size() == 0) begin
              check("wdata_avail", 32'd0, 32'd1);
            end else begin
              e = exp_q.pop_front();
              check("wdata", 32'(user_wdata), 32'(e));
            end
            popped++;
          end
          phase = ~phase;
          @(negedge clk);
        end
        user_wen = 1'b0;
        if (!aborted) begin
          user_wdone      = 1'b1;
          free_strobe_ctl = free_on_done;
          @(negedge clk);
          user_wdone      = 1'b0;
          free_strobe_ctl = 1'b0;
          bursts_done++;
        end
      end
    end
  end

  task automatic stream(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      if (in_ready) exp_q.push_back(in_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int target, input int limit, input string tag);
    int c;
    c = 0;
    while (bursts_done < target && c < limit) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(bursts_done), 32'(target));
  endtask

  task automatic free_pulse(input logic [9:0] w);
    @(negedge clk);
    free_strobe_tb = 1'b1;
    free_words_tb  = w;
    @(negedge clk);
    free_strobe_tb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_req.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    int c;
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    free_strobe_tb = 1'b0;
    free_words_tb  = '0;
    half_duty      = 1'b0;
    free_on_done   = 1'b0;
    abort_after    = 0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wreq", 32'(user_wreq), 32'd0);
    check("rst_waddr", 32'(user_waddr), 32'd0);
    check("rst_wsize", 32'(user_wsize), 32'd0);
    check("rst_fill", 32'(ring_fill), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    check("in_ready_pre", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_post", 32'(in_ready), 32'd1);

    // One full burst of 0..255
    exp_req.push_back({24'd0, 10'd256});
    stream(256, 16'h0000);
    wait_bursts(1, 2000, "burstA_done");
    check("fillA", 32'(ring_fill), 32'd256);

    // Burst at the ring end with simultaneous free: wraps, fill unchanged
    free_on_done = 1'b1;
    exp_req.push_back({24'd256, 10'd256});
    stream(256, 16'h1000);
    wait_bursts(2, 2000, "burstB_done");
    free_on_done = 1'b0;
    check("fill_done_free", 32'(ring_fill), 32'd256);
    exp_req.push_back({24'd0, 10'd256});
    stream(256, 16'h2000);
    wait_bursts(3, 2000, "burst_wrap_done");
    check("fill_after_wrap", 32'(ring_fill), 32'd512);
    free_pulse(10'd300);
    check("fill_free300", 32'(ring_fill), 32'd212);
    free_pulse(10'd300);
    check("fill_clamp", 32'(ring_fill), 32'd0);

    // 600 words with 50% consume rate
    do_reset();
    half_duty = 1'b1;
    exp_req.push_back({24'd0, 10'd256});
    exp_req.push_back({24'd256, 10'd256});
    stream(600, 16'h3000);
    wait_bursts(5, 3000, "burstC_done");
    half_duty = 1'b0;
    check("dropsC", 32'(drop_count), 32'd0);
    check("fillC", 32'(ring_fill), 32'd512);
    check("leftC", 32'(exp_q.size()), 32'd88);

    // Ring full: FIFO fills and the rest is dropped
    do_reset();
    exp_req.push_back({24'd0, 10'd256});
    exp_req.push_back({24'd256, 10'd256});
    stream(1200, 16'h4000);
    wait_bursts(7, 2000, "burstD_done");
    check("fillD", 32'(ring_fill), 32'd512);
    check("in_ready_full", 32'(in_ready), 32'd0);
    check("dropsD", 32'(drop_count), 32'd176);
    check("leftD", 32'(exp_q.size()), 32'd512);
    exp_req.push_back({24'd0, 10'd256});
    free_pulse(10'd256);
    check("fill_freed", 32'(ring_fill), 32'd256);
    wait_bursts(8, 2000, "burstD3_done");
    check("fillD3", 32'(ring_fill), 32'd512);
    check("dropsD3", 32'(drop_count), 32'd176);

    // Reset mid-burst after 100 pops
    do_reset();
    abort_after = 100;
    exp_req.push_back({24'd0, 10'd256});
    stream(256, 16'h5000);
    c = 0;
    while (!aborted && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("abort_reached", 32'(aborted), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_wreq", 32'(user_wreq), 32'd0);
    check("arst_waddr", 32'(user_waddr), 32'd0);
    check("arst_wsize", 32'(user_wsize), 32'd0);
    check("arst_fill", 32'(ring_fill), 32'd0);
    check("arst_drops", 32'(drop_count), 32'd0);
    abort_after = 0;
    exp_q.delete();
    exp_req.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_req.push_back({24'd0, 10'd256});
    stream(256, 16'h6000);
    wait_bursts(9, 2000, "burstE_done");
    check("fillE", 32'(ring_fill), 32'd256);

    // Partial data left idle
`ifdef SDRAM_BURST_WRITER_FLUSH_EN
    exp_req.push_back({24'd256, 10'd40});
    stream(40, 16'h7000);
    wait_bursts(10, 4600, "flush_done");
    check("fill_flush", 32'(ring_fill), 32'd296);
`else
    stream(40, 16'h7000);
    c = 0;
    repeat (4400) begin
      @(negedge clk);
      if (user_wreq) c++;
    end
    check("no_flush_req", 32'(c), 32'd0);
    check("fill_noflush", 32'(ring_fill), 32'd256);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_burst_writer.md
Name: sdram_burst_writer

Overview:
- Sits directly upstream of the SDRAM controller write port, in the slot the memory test generator fills today.
- Accepts a 16-bit capture word stream and buffers it in an internal FWFT FIFO.
- Issues fixed-size burst write requests into a circular region of SDRAM.
- Tracks ring occupancy so a downstream reader can later drain the ring and return space.

Parameters:
- ADDR_W, 24: SDRAM word-address width.
- BURST, 256: words per full burst; must be at most 1023.
- FIFO_AW, 9: log2 of internal FIFO depth, giving 512 words; must exceed log2(BURST).
- RING_BASE, 24'h000000: first word address of the ring.
- RING_WORDS, 24'h100000: ring size in words; must be a multiple of BURST.

Ports:
- clk in 1: single clock (SDRAM clock domain).
- rst_n in 1: asynchronous active-low reset.
- in_data in 16: capture word.
- in_valid in 1: in_data is valid this cycle.
- in_ready out 1: FIFO can accept a word.
- user_wreq out 1: burst write request.
- user_wstart in 1: controller accepted the request.
- user_wdone in 1: controller finished the burst.
- user_waddr out ADDR_W: burst start address.
- user_wsize out 10: burst length in words.
- user_wen in 1: controller consumes user_wdata this cycle.
- user_wdata out 16: FIFO head word.
- free_strobe in 1: reader returns free_words of ring space.
- free_words in 10: word count returned.
- ring_fill out ADDR_W+1: words held in the ring.
- drop_count out 16: saturating count of lost input words.

Behaviour:
- Reset values: in_ready=0, user_wreq=0, user_waddr=RING_BASE, user_wsize=0, ring_fill=0, drop_count=0, FIFO empty, write pointer=RING_BASE, state IDLE. in_ready rises the first clk after rst_n deasserts.
- Input: a word is pushed when in_valid and in_ready. in_valid and !in_ready increments drop_count, saturating at 16'hFFFF; the input is never stalled upstream.
- in_ready = FIFO not full.
- Output data: user_wdata always equals the FIFO head (FWFT). user_wen pops the head; the new head is visible the next cycle. user_wen while the FIFO is empty is a protocol error: no pop, no state change.
- States:
  - IDLE -> REQ when FIFO level >= BURST and (RING_WORDS - ring_fill) >= BURST. Latch user_waddr = write pointer and user_wsize = BURST.
  - REQ: user_wreq=1, held until user_wstart. On user_wstart -> XFER; user_wreq drops the same edge.
  - XFER: pops on user_wen. On user_wdone -> IDLE. Write pointer advances by BURST, wrapping to RING_BASE at RING_BASE+RING_WORDS. ring_fill += BURST.
- Bursts never cross the ring end; this follows from the RING_WORDS multiple-of-BURST rule.
- ring_fill arithmetic:
  - free_strobe subtracts free_words, clamped at 0.
  - free_strobe in the same cycle as user_wdone applies both: fill + BURST - free_words.
- Push and pop in the same cycle leave the FIFO level unchanged; this is allowed when full.
- ring_fill never exceeds RING_WORDS. A full ring parks the block in IDLE while the FIFO fills and then drops.
- Reset mid-burst aborts immediately. The controller shares the reset, so no partial burst completes.

Optional Feature:
- Macro: SDRAM_BURST_WRITER_FLUSH_EN.
- With the macro defined:
  - A 16-bit idle counter counts cycles in IDLE with FIFO level in 1..BURST-1 and no push.
  - At 16'd4096 it requests a short burst: user_wsize = level, capped so it cannot cross the ring end. It still requires ring space >= level.
  - The write pointer and ring_fill advance by user_wsize.
  - The counter clears on any push or on leaving IDLE.
- Without the macro: only full BURST transfers occur, and the counter logic is absent.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, REQ, XFER};
  - the SDRAM word-address width constant;
  - the user_wsize width constant (10).
- One natural sub-module: sdram_burst_fifo, a synchronous FWFT FIFO with level output and async active-low reset. It is reusable for the read-side drainer.

Test Plan:
- Push 256 words 0..255 at one word per cycle, with the controller model asserting user_wstart 3 cycles after the request -> one request with user_waddr=0 and user_wsize=256, data 0..255 in order, ring_fill=256.
- Stream 600 words continuously with user_wen at 50% duty -> no drops, and all 512 words of the two completed bursts appear in order at addresses 0 and 256.
- RING_WORDS=512, no free_strobe, stream 1200 words -> two bursts, ring_fill=512, FIFO fills to 512, then in_ready=0 and drop_count=176. Then free_strobe with free_words=256 -> a third burst at address 0.
- Wrap case: ring_fill at 256 with the pointer at RING_BASE+RING_WORDS-256, then complete a burst -> pointer wraps to RING_BASE. Also pulse free_strobe=256 in the same cycle as user_wdone -> ring_fill unchanged.
- Deassert rst_n during XFER after 100 user_wen pops -> all outputs return to reset values asynchronously, the FIFO is empty, and the next burst starts at RING_BASE.
- SDRAM_BURST_WRITER_FLUSH_EN defined: push 40 words, then idle -> after 4096 cycles a request with user_wsize=40. Without the macro, no request is issued.
